ldq_pointer_ctrl: RTL and testbench

Owns the load-queue (LDQ) allocation state: head, tail, occupancy and per-entry valid bits. It sits directly upstream of the dispatched-load allocator. It consumes that allocator's new-load count, and produces the ldqHead/ldqTail/ldqInsts values the allocator uses to assign LDQ ids. It also retires loads at commit, empties the queue on branch-mispredict/exception recovery, and raises the dispatch stall when the LDQ lacks room.

---
 rtl/ldq_pointer_ctrl_pkg.sv | 13 +
 rtl/ldq_pointer_ctrl_if.sv | 46 ++++
 rtl/ldq_pointer_ctrl_range_mask.sv | 17 +
 rtl/ldq_pointer_ctrl.sv | 88 ++++++++
 tb/tb_ldq_pointer_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ldq_pointer_ctrl_pkg.sv
// Load-queue sizing constants and index/count types
// shared by the LDQ pointer controller and its helpers.
package ldq_pointer_ctrl_pkg;

  localparam int SIZE_LSQ       = 32;
  localparam int SIZE_LSQ_LOG   = 5;
  localparam int DISPATCH_WIDTH = 4;
  localparam int COMMIT_WIDTH   = 4;

  typedef logic [SIZE_LSQ_LOG-1:0] ldq_idx_t;
  typedef logic [SIZE_LSQ_LOG:0]   ldq_cnt_t;

endpackage

// File: rtl/ldq_pointer_ctrl_if.sv
// Dispatch/commit/recover inputs and LDQ state outputs
// of the load-queue pointer controller.
interface ldq_pointer_ctrl_if;
  import ldq_pointer_ctrl_pkg::*;

  logic                dispatchValid_i;
  ldq_idx_t            cntLdNew_i;
  logic [2:0]          commitCnt_i;
  logic                recoverFlag_i;
  ldq_idx_t            ldqHead_o;
  ldq_idx_t            ldqTail_o;
  ldq_cnt_t            ldqInsts_o;
  logic [SIZE_LSQ-1:0] ldqValid_o;
  logic                ldqStall_o;
  logic                ldqEmpty_o;
  logic                ldqError_o;

  modport master (
    output dispatchValid_i,
    output cntLdNew_i,
    output commitCnt_i,
    output recoverFlag_i,
    input  ldqHead_o,
    input  ldqTail_o,
    input  ldqInsts_o,
    input  ldqValid_o,
    input  ldqStall_o,
    input  ldqEmpty_o,
    input  ldqError_o
  );

  modport slave (
    input  dispatchValid_i,
    input  cntLdNew_i,
    input  commitCnt_i,
    input  recoverFlag_i,
    output ldqHead_o,
    output ldqTail_o,
    output ldqInsts_o,
    output ldqValid_o,
    output ldqStall_o,
    output ldqEmpty_o,
    output ldqError_o
  );

endinterface

// File: rtl/ldq_pointer_ctrl_range_mask.sv
// Wrapped range mask: bit i set when entry i lies in
// [base, base+cnt) modulo the queue size.
module ldq_range_mask
  import ldq_pointer_ctrl_pkg::*;
(
  input  ldq_idx_t            base,
  input  ldq_cnt_t            cnt,
  output logic [SIZE_LSQ-1:0] mask
);

  for (genvar i = 0; i < SIZE_LSQ; i++) begin : g_bit
    ldq_idx_t off;
    assign off     = ldq_idx_t'(i) - base;
    assign mask[i] = ldq_cnt_t'(off) < cnt;
  end

endmodule

// File: rtl/ldq_pointer_ctrl.sv
// LDQ head/tail/occupancy/valid tracking with dispatch
// allocation, commit retirement, flush and stall.
module ldq_pointer_ctrl
  import ldq_pointer_ctrl_pkg::*;
(
  input logic          clk,
  input logic          reset,
  ldq_pointer_ctrl_if.slave bus
);

  ldq_idx_t            head;
  ldq_idx_t            tail;
  ldq_cnt_t            insts;
  logic [SIZE_LSQ-1:0] valid;
  logic                error;

  ldq_cnt_t            room;
  logic                stall;
  logic                ovf;
  logic                udf;
  logic                disp_acc;
  logic                com_acc;
  ldq_cnt_t            disp_n;
  ldq_cnt_t            com_n;
  logic [SIZE_LSQ-1:0] set_mask;
  logic [SIZE_LSQ-1:0] clr_mask;

  // Stall looks only at registered occupancy; same-cycle
  // commits never free room for the incoming bundle.
  assign room  = ldq_cnt_t'(SIZE_LSQ) - insts;
  assign stall = bus.dispatchValid_i &
                 (ldq_cnt_t'(bus.cntLdNew_i) > room);

  assign ovf = bus.dispatchValid_i &
               (bus.cntLdNew_i > ldq_idx_t'(DISPATCH_WIDTH));
  assign udf = ldq_cnt_t'(bus.commitCnt_i) > insts;

  assign disp_acc = bus.dispatchValid_i & ~stall &
                    ~ovf & ~bus.recoverFlag_i;
  assign com_acc  = (bus.commitCnt_i != 3'd0) &
                    ~udf & ~bus.recoverFlag_i;

  assign disp_n = disp_acc ? ldq_cnt_t'(bus.cntLdNew_i) : '0;
  assign com_n  = com_acc  ? ldq_cnt_t'(bus.commitCnt_i) : '0;

  ldq_range_mask u_set (
    .base (tail),
    .cnt  (disp_n),
    .mask (set_mask)
  );

  ldq_range_mask u_clr (
    .base (head),
    .cnt  (com_n),
    .mask (clr_mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      insts <= '0;
      valid <= '0;
      error <= 1'b0;
    end else if (bus.recoverFlag_i) begin
      head  <= '0;
      tail  <= '0;
      insts <= '0;
      valid <= '0;
    end else begin
      head  <= head + ldq_idx_t'(com_n);
      tail  <= tail + ldq_idx_t'(disp_n);
      insts <= insts + disp_n - com_n;
      valid <= (valid & ~clr_mask) | set_mask;
      if (ovf | udf)
        error <= 1'b1;
    end
  end

  assign bus.ldqHead_o  = head;
  assign bus.ldqTail_o  = tail;
  assign bus.ldqInsts_o = insts;
  assign bus.ldqValid_o = valid;
  assign bus.ldqStall_o = stall;
  assign bus.ldqEmpty_o = (insts == '0);
  assign bus.ldqError_o = error;

endmodule

// File: tb/tb_ldq_pointer_ctrl.sv
// Directed and randomized checks of ldq_pointer_ctrl
// against an occupancy-level queue model.
module tb_ldq_pointer_ctrl;
  import ldq_pointer_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  bit   cmp_en;

  int m_head;
  int m_tail;
  int m_cnt;
  bit m_err;

  ldq_pointer_ctrl_if bus ();

  ldq_pointer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Valid entries are exactly those within [head, head+count).
  function automatic logic [31:0] exp_valid();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < m_cnt; k++)
      v[(m_head + k) % 32] = 1'b1;
    return v;
  endfunction

  function automatic bit exp_stall();
    return bus.dispatchValid_i &&
           (int'(bus.cntLdNew_i) > 32 - m_cnt);
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = 0;
    m_cnt  = 0;
    m_err  = 0;
  endtask

  task automatic model_update();
    int  cnt;
    int  cc;
    bit  dv;
    bit  ovf;
    bit  udf;
    bit  dacc;
    bit  cacc;
    dv = bus.dispatchValid_i;
    cnt = int'(bus.cntLdNew_i);
    cc = int'(bus.commitCnt_i);
    if (bus.recoverFlag_i) begin
      m_head = 0;
      m_tail = 0;
      m_cnt  = 0;
      return;
    end
    ovf  = dv && cnt > 4;
    udf  = cc > m_cnt;
    dacc = dv && !ovf && !exp_stall();
    cacc = !udf;
    if (ovf || udf) m_err = 1;
    if (dacc) begin
      m_tail = (m_tail + cnt) % 32;
      m_cnt += cnt;
    end
    if (cacc) begin
      m_head = (m_head + cc) % 32;
      m_cnt -= cc;
    end
  endtask

  task automatic drive(bit dv, int cnt, int cc, bit rec);
    bus.dispatchValid_i = dv;
    bus.cntLdNew_i      = cnt[4:0];
    bus.commitCnt_i     = cc[2:0];
    bus.recoverFlag_i   = rec;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(bit dv, int cnt, int cc, bit rec);
    drive(dv, cnt, cc, rec);
    tick();
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("head",  bus.ldqHead_o,  m_head);
      chk("tail",  bus.ldqTail_o,  m_tail);
      chk("insts", bus.ldqInsts_o, m_cnt);
      chk("valid", bus.ldqValid_o, exp_valid());
      chk("stall", bus.ldqStall_o, exp_stall());
      chk("empty", bus.ldqEmpty_o, m_cnt == 0);
      chk("error", bus.ldqError_o, m_err);
    end
  end

  task automatic rand_phase(int cycles, int err_odds);
    int cnt;
    int cc;
    for (int n = 0; n < cycles; n++) begin
      cnt = $urandom_range(0, 4);
      if ($urandom_range(0, err_odds) == 0) cnt = $urandom_range(0, 31);
      cc = $urandom_range(0, m_cnt < 4 ? m_cnt : 4);
      if ($urandom_range(0, err_odds) == 0) cc = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, cnt, cc,
           $urandom_range(0, 60) == 0);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cmp_en = 0;
    model_reset();
    drive(0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_head",  bus.ldqHead_o, 0);
    chk("rst_tail",  bus.ldqTail_o, 0);
    chk("rst_insts", bus.ldqInsts_o, 0);
    chk("rst_valid", bus.ldqValid_o, 0);
    chk("rst_empty", bus.ldqEmpty_o, 1);
    chk("rst_error", bus.ldqError_o, 0);
    @(negedge clk);
    reset  = 1'b1;
    cmp_en = 1;

    step(1, 3, 0, 0);
    chk("d3_tail",  bus.ldqTail_o, 3);
    chk("d3_insts", bus.ldqInsts_o, 3);
    chk("d3_valid", bus.ldqValid_o, 32'h0000_0007);
    chk("d3_empty", bus.ldqEmpty_o, 0);

    repeat (6) step(1, 4, 0, 0);
    step(1, 3, 0, 0);
    repeat (7) step(0, 0, 4, 0);
    chk("pre_wrap_head", bus.ldqHead_o, 28);
    chk("pre_wrap_tail", bus.ldqTail_o, 30);
    step(1, 4, 0, 0);
    chk("wrap_tail",  bus.ldqTail_o, 2);
    chk("wrap_insts", bus.ldqInsts_o, 6);
    chk("wrap_valid", bus.ldqValid_o, 32'hF000_0003);
    step(0, 0, 2, 0);
    chk("wrap_c_head",  bus.ldqHead_o, 30);
    chk("wrap_c_insts", bus.ldqInsts_o, 4);

    repeat (6) step(1, 4, 0, 0);
    step(1, 1, 0, 0);
    chk("nf_insts", bus.ldqInsts_o, 29);
    drive(1, 4, 0, 0);
    #1;
    chk("nf_stall", bus.ldqStall_o, 1);
    tick();
    chk("nf_hold_insts", bus.ldqInsts_o, 29);
    chk("nf_hold_tail",  bus.ldqTail_o, 27);
    drive(1, 3, 0, 0);
    #1;
    chk("nf3_stall", bus.ldqStall_o, 0);
    tick();
    chk("full_insts", bus.ldqInsts_o, 32);
    chk("full_head",  bus.ldqHead_o, 30);
    chk("full_tail",  bus.ldqTail_o, 30);
    chk("full_empty", bus.ldqEmpty_o, 0);
    chk("full_valid", bus.ldqValid_o, 32'hFFFF_FFFF);

    repeat (5) step(0, 0, 4, 0);
    step(0, 0, 2, 0);
    chk("sim_pre_insts", bus.ldqInsts_o, 10);
    step(1, 2, 4, 0);
    chk("sim_insts", bus.ldqInsts_o, 8);
    chk("sim_head",  bus.ldqHead_o, 24);
    chk("sim_tail",  bus.ldqTail_o, 0);
    chk("sim_valid", bus.ldqValid_o, 32'hFF00_0000);

    repeat (2) step(1, 4, 0, 0);
    step(1, 1, 0, 0);
    chk("rec_pre_insts", bus.ldqInsts_o, 17);
    step(1, 4, 1, 1);
    chk("rec_head",  bus.ldqHead_o, 0);
    chk("rec_tail",  bus.ldqTail_o, 0);
    chk("rec_insts", bus.ldqInsts_o, 0);
    chk("rec_valid", bus.ldqValid_o, 0);
    chk("rec_error", bus.ldqError_o, 0);

    step(1, 1, 0, 0);
    step(0, 0, 3, 0);
    chk("udf_head",  bus.ldqHead_o, 0);
    chk("udf_insts", bus.ldqInsts_o, 1);
    chk("udf_error", bus.ldqError_o, 1);
    step(1, 5, 0, 0);
    chk("ovf_tail",  bus.ldqTail_o, 1);
    step(0, 0, 0, 0);
    chk("err_sticky", bus.ldqError_o, 1);

    rand_phase(3000, 40);

    step(1, 2, 0, 1);
    step(1, 3, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_head",  bus.ldqHead_o, 0);
    chk("arst_tail",  bus.ldqTail_o, 0);
    chk("arst_insts", bus.ldqInsts_o, 0);
    chk("arst_valid", bus.ldqValid_o, 0);
    chk("arst_error", bus.ldqError_o, 0);
    chk("arst_empty", bus.ldqEmpty_o, 1);
    model_reset();
    drive(1, 4, 2, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_tail", bus.ldqTail_o, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    rand_phase(3000, 400);

    @(negedge clk);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
